exc_ctrl: RTL
=============

# exc_ctrl

Exception/return sequencer for the static MIPS pipeline. It sits between the decode stage and the CP0 register file. It collects trap requests (syscall, break, teq), eret and, optionally, external interrupts, and applies priority and Status masking. It stalls until the pipeline is safe, then drives a one-cycle exception or eret commit into CP0 together with the flush and PC-redirect controls.

## Interface
- IRQ_W, 4, number of external interrupt lines
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-high
- id_pc  in  32  PC of the instruction currently in ID
- req_syscall / req_break / req_teq  in  1 each  trap decoded in ID (req_teq already qualified by rs==rt)
- req_eret  in  1  eret decoded in ID
- irq  in  IRQ_W  level interrupt requests, synchronous to clk
- status  in  32  CP0 Status (bit0 IE, bit1 syscall en, bit2 break en, bit3 teq en)
- mtc0_active  in  1  mtc0 in flight toward CP0 this cycle
- md_busy  in  1  multi-cycle mul/div unit busy
- stall  out  1  freeze IF/ID
- flush  out  1  squash IF/ID/EX contents
- pc_redirect  out  1  PC takes CP0 epc_out
- cp0_exception  out  1  CP0 exception strobe
- cp0_eret  out  1  CP0 eret strobe
- cp0_cause  out  5  ExcCode to CP0
- cp0_pc  out  32  EPC value to CP0
- irq_pending  out  IRQ_W  latched pending interrupts

## Operation
- Event selection in IDLE, highest priority first:
  - teq (ExcCode 13) if status[3]
  - break (9) if status[2]
  - syscall (8) if status[1]
  - eret
  - interrupt (0) if status[0] and irq_pending≠0
- A masked trap is ignored; the instruction proceeds as a NOP.
- irq_pending[i] is set when irq[i]=1. It clears only when interrupt i is entered. Only the lowest pending index is serviced per entry.
- On selection, latch code and id_pc into cp0_cause/cp0_pc registers.
- States:
  - IDLE: no event → stay. Event with (md_busy|mtc0_active) → DRAIN. Event otherwise → ENTER (trap/irq) or RETURN (eret).
  - DRAIN: stall=1. Exit to ENTER/RETURN in the first cycle md_busy=0 and mtc0_active=0. New requests are ignored, except that a pending irq does not preempt the latched event.
  - ENTER: one cycle; cp0_exception=1, flush=1, pc_redirect=1 (CP0 supplies the exception vector because eret=0). → GUARD.
  - RETURN: one cycle; cp0_eret=1, flush=1, pc_redirect=1 (CP0 supplies EPC combinationally). → GUARD.
  - GUARD: one cycle; all requests ignored, since ID holds a flushed bubble. → IDLE.
- cp0_exception and cp0_eret are never both 1. Neither is asserted in a cycle where mtc0_active=1, because CP0 gives mtc0 priority and the commit would be lost.
- EPC is the trapping instruction's PC. For an interrupt it is the PC of the flushed ID instruction, so it re-executes on return.

## Timing
- Reset (rst high at a clk edge): state=IDLE. stall, flush, pc_redirect, cp0_exception and cp0_eret are 0. cp0_cause=0, cp0_pc=0, irq_pending=0. This applies in any state; an exception being drained is abandoned.
- Request in IDLE at cycle T with no hazard: ENTER/RETURN outputs at T+1, GUARD at T+2, new event accepted from T+3.
- With hazard: stall from T+1 through the last DRAIN cycle; commit one cycle after hazards clear.
- stall=0 in ENTER/RETURN/GUARD; flush and pc_redirect are high only in ENTER/RETURN.
- A simultaneous trap and eret in ID are treated as a trap. A simultaneous irq and trap: the trap wins and the irq stays pending.
- irq asserted in the same cycle as selection becomes pending but is not considered until the next IDLE.

## Configuration
- EXC_CTRL_IRQ_EN defined: interrupt pending logic and interrupt entry are present as described.
- EXC_CTRL_IRQ_EN undefined: the irq port exists but is ignored, irq_pending is tied to 0, and only traps and eret are sequenced.

## Test plan
- Reset, status=0x0F, req_syscall with id_pc=0x00400010 → at T+1, cp0_exception=1, cp0_cause=8, cp0_pc=0x00400010, flush=pc_redirect=1; GUARD at T+2; IDLE at T+3.
- req_teq and req_syscall together → cause=13; with status=0x07 the same stimulus gives cause=8.
- req_break while md_busy is high for 3 cycles → stall=1 for 3 cycles, then cp0_exception=1 for exactly 1 cycle with cause=9.
- req_eret → cp0_eret=1, pc_redirect=1, cp0_exception=0 for one cycle; req_eret with mtc0_active=1 → DRAIN one cycle, then RETURN.
- IRQ_EN, status=0x01, irq=4'b0110 pulsed → ENTER with cause=0, irq_pending becomes 4'b0100, and the next IDLE services bit 2.
- rst asserted during DRAIN → next cycle IDLE with all outputs 0; no cp0_exception is ever emitted.

Source files
------------

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/eret sequencer between decode and CP0.
// Selects the highest-priority enabled trap, eret or interrupt in IDLE, waits
// out mul/div and mtc0 hazards, then issues a one-cycle CP0 commit with
// flush/redirect followed by a one-cycle guard bubble.
// Optional feature macro: EXC_CTRL_IRQ_EN enables interrupt pending/entry.
module exc_ctrl #(
  parameter int IRQ_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_pc,
  input  logic             req_syscall,
  input  logic             req_break,
  input  logic             req_teq,
  input  logic             req_eret,
  input  logic [IRQ_W-1:0] irq,
  input  logic [31:0]      status,
  input  logic             mtc0_active,
  input  logic             md_busy,
  output logic             stall,
  output logic             flush,
  output logic             pc_redirect,
  output logic             cp0_exception,
  output logic             cp0_eret,
  output logic [4:0]       cp0_cause,
  output logic [31:0]      cp0_pc,
  output logic [IRQ_W-1:0] irq_pending
);

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_TR  = 5'd13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_ENTER,
    S_RETURN,
    S_GUARD
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       cause_q, cause_d;
  logic [31:0]      epc_q, epc_d;
  logic             eret_q, eret_d;
  logic             ev_sel;
  logic             take_irq;
  logic             hazard;
  logic [IRQ_W-1:0] pend_q;

  logic unused_status;
  assign unused_status = ^status[31:4];

  assign hazard      = md_busy | mtc0_active;
  assign cp0_cause   = cause_q;
  assign cp0_pc      = epc_q;
  assign irq_pending = pend_q;

  // State and latched-event registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      eret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      eret_q  <= eret_d;
    end
  end

  // Event selection, next-state and commit/stall outputs.
  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    epc_d         = epc_q;
    eret_d        = eret_q;
    ev_sel        = 1'b0;
    take_irq      = 1'b0;
    stall         = 1'b0;
    flush         = 1'b0;
    pc_redirect   = 1'b0;
    cp0_exception = 1'b0;
    cp0_eret      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_teq && status[3]) begin
          ev_sel  = 1'b1;
          cause_d = EXC_TR;
          epc_d   = id_pc;
          eret_d  = 1'b0;
        end else if (req_break && status[2]) begin
          ev_sel  = 1'b1;
          cause_d = EXC_BP;
          epc_d   = id_pc;
          eret_d  = 1'b0;
        end else if (req_syscall && status[1]) begin
          ev_sel  = 1'b1;
          cause_d = EXC_SYS;
          epc_d   = id_pc;
          eret_d  = 1'b0;
        end else if (req_eret) begin
          ev_sel  = 1'b1;
          eret_d  = 1'b1;
        end else if (status[0] && (|pend_q)) begin
          ev_sel   = 1'b1;
          take_irq = 1'b1;
          cause_d  = EXC_INT;
          epc_d    = id_pc;
          eret_d   = 1'b0;
        end
        if (ev_sel) begin
          if (hazard)      state_d = S_DRAIN;
          else if (eret_d) state_d = S_RETURN;
          else             state_d = S_ENTER;
        end
      end
      S_DRAIN: begin
        stall = 1'b1;
        if (!hazard) state_d = eret_q ? S_RETURN : S_ENTER;
      end
      // A late mtc0 would win the CP0 write port and swallow the commit, so
      // the commit is deferred back through DRAIN with IF/ID held.
      S_ENTER: begin
        if (mtc0_active) begin
          stall   = 1'b1;
          state_d = S_DRAIN;
        end else begin
          cp0_exception = 1'b1;
          flush         = 1'b1;
          pc_redirect   = 1'b1;
          state_d       = S_GUARD;
        end
      end
      S_RETURN: begin
        if (mtc0_active) begin
          stall   = 1'b1;
          state_d = S_DRAIN;
        end else begin
          cp0_eret    = 1'b1;
          flush       = 1'b1;
          pc_redirect = 1'b1;
          state_d     = S_GUARD;
        end
      end
      S_GUARD: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef EXC_CTRL_IRQ_EN
  logic [IRQ_W-1:0] irq_low;
  logic [IRQ_W-1:0] sel_q, sel_d;
  logic [IRQ_W-1:0] pend_d;

  // Isolate the lowest pending line (two's-complement trick).
  assign irq_low = pend_q & (~pend_q + IRQ_W'(1));

  // Remember which line (if any) the latched event services.
  always_comb begin
    sel_d = sel_q;
    if (ev_sel) sel_d = take_irq ? irq_low : '0;
  end

  // Pending bits set on irq, cleared only when their entry commits.
  always_comb begin
    pend_d = pend_q | irq;
    if (cp0_exception) pend_d = (pend_q & ~sel_q) | irq;
  end

  // Interrupt pending and selection registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      sel_q  <= '0;
    end else begin
      pend_q <= pend_d;
      sel_q  <= sel_d;
    end
  end
`else
  logic unused_irq;
  assign pend_q     = '0;
  assign unused_irq = ^{irq, ev_sel, take_irq};
`endif

endmodule
